// File: rtl/mpsoc_wb_burst_ram_slave.sv
// Wishbone B3 burst-capable RAM slave: byte-maskable memory with classic, constant
// and incrementing (linear / wrap4/8/16) bursts, programmable first-beat latency and range error.
module mpsoc_wb_burst_ram_slave #(
  parameter int unsigned    AW          = 32,
  parameter int unsigned    DW          = 32,
  parameter int unsigned    MEM_WORDS   = 1024,
  parameter logic [AW-1:0]  BASE_ADDR   = '0,
  parameter int unsigned    WAIT_STATES = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o
);

  localparam int unsigned NB      = DW / 8;
  localparam int unsigned ADR_LSB = $clog2(NB);
  localparam int unsigned IW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            ack_nxt, err_nxt, load;
  logic [DW-1:0]   dat_nxt, rd_data, bmask;
  logic [AW-1:0]   adr_r, adr_nxt, next_adr, rd_adr, wrap_mask;
  logic [IW-1:0]   wr_idx, rd_idx;
  logic            req, wr_fire;

  logic [DW-1:0]   mem [MEM_WORDS];

  function automatic logic [AW-1:0] word_index(input logic [AW-1:0] a);
    logic [AW-1:0] d;
    d = a - BASE_ADDR;
    return d >> ADR_LSB;
  endfunction

  // Extra MSB catches addresses below BASE_ADDR as a borrow.
  function automatic logic out_of_range(input logic [AW-1:0] a);
    logic [AW:0] d;
    d = {1'b0, a} - {1'b0, BASE_ADDR};
    return d[AW] || ((d[AW-1:0] >> ADR_LSB) >= AW'(MEM_WORDS));
  endfunction

  for (genvar g = 0; g < NB; g++) begin : g_bmask
    assign bmask[8*g +: 8] = {8{wb_sel_i[g]}};
  end

  assign req      = wb_cyc_i & wb_stb_i;
  assign wr_fire  = wb_ack_o & req & wb_we_i & ~out_of_range(wb_adr_i);
  assign wr_idx   = IW'(word_index(wb_adr_i));
  assign rd_idx   = IW'(word_index(rd_adr));
  assign wb_rty_o = 1'b0;

  always_comb begin
    case (wb_bte_i)
      2'b01:   wrap_mask = AW'(4 * NB - 1);
      2'b10:   wrap_mask = AW'(8 * NB - 1);
      2'b11:   wrap_mask = AW'(16 * NB - 1);
      default: wrap_mask = '1;
    endcase
    next_adr = (adr_r & ~wrap_mask) | ((adr_r + AW'(NB)) & wrap_mask);
  end

  always_comb begin
    rd_adr = wb_adr_i;
    if (state == S_ACTIVE)
      rd_adr = (wb_cti_i == 3'b010) ? next_adr : adr_r;
  end

  // Forward the beat being written so a constant burst re-read sees the new bytes.
  always_comb begin
    rd_data = mem[rd_idx];
    if (wr_fire && (wr_idx == rd_idx))
      rd_data = (rd_data & ~bmask) | (wb_dat_i & bmask);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    adr_nxt   = adr_r;
    dat_nxt   = wb_dat_o;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            load = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!req)               state_nxt = S_IDLE;
        else if (cnt == 4'd1)   load      = 1'b1;
        else                    cnt_nxt   = cnt - 4'd1;
      end
      S_ACTIVE: begin
        // An err beat, a dropped strobe or a closing classic/end beat all land here.
        state_nxt = S_IDLE;
        if (req && wb_ack_o) begin
          case (wb_cti_i)
            3'b010: begin
              state_nxt = S_ACTIVE;
              if (out_of_range(next_adr)) begin
                err_nxt = 1'b1;
              end else begin
                ack_nxt = 1'b1;
                adr_nxt = next_adr;
                dat_nxt = rd_data;
              end
            end
            3'b001: begin
              state_nxt = S_ACTIVE;
              ack_nxt   = 1'b1;
              dat_nxt   = rd_data;
            end
            default: ;
          endcase
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (load) begin
      state_nxt = S_ACTIVE;
      adr_nxt   = wb_adr_i;
      if (out_of_range(wb_adr_i)) begin
        err_nxt = 1'b1;
        dat_nxt = '0;
      end else begin
        ack_nxt = 1'b1;
        dat_nxt = rd_data;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      adr_r    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wb_ack_o <= ack_nxt;
      wb_err_o <= err_nxt;
      wb_dat_o <= dat_nxt;
      adr_r    <= adr_nxt;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_fire)
      mem[wr_idx] <= (mem[wr_idx] & ~bmask) | (wb_dat_i & bmask);
  end

endmodule

// File: tb/tb_mpsoc_wb_burst_ram_slave.sv
// Directed and random Wishbone burst traffic against a word/byte-level memory model.
module tb_mpsoc_wb_burst_ram_slave;

  localparam int unsigned MW = 64;
  localparam int unsigned WS = 2;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic        wb_ack_o, wb_err_o, wb_rty_o;

  mpsoc_wb_burst_ram_slave #(
    .AW(32), .DW(32), .MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_STATES(WS)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int unsigned cycles = 0;
  always @(posedge wb_clk_i) cycles <= cycles + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [MW];
  logic [3:0]  kn  [MW];
  logic [31:0] ba [64], bw [64], br [64];
  logic [3:0]  bs [64];
  int          bt [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Burst address sequence from the wrap-span arithmetic.
  function automatic logic [31:0] m_next(input logic [31:0] a, input logic [2:0] cb, input logic [1:0] bte);
    int unsigned span;
    logic [31:0] base;
    if (cb == 3'b001) return a;
    case (bte)
      2'd1:    span = 16;
      2'd2:    span = 32;
      2'd3:    span = 64;
      default: span = 0;
    endcase
    if (span == 0) return a + 4;
    base = a - (a % span);
    return base + ((a - base + 4) % span);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    int i;
    i = int'(a / 4);
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    mdl[i] = (mdl[i] & ~m) | (d & m);
    kn[i]  = kn[i] | s;
  endtask

  function automatic int exp_good(input int n);
    int g;
    g = 0;
    for (int k = 0; k < n; k++) begin
      if (ba[k] >= 32'(4 * MW)) break;
      g++;
    end
    return g;
  endfunction

  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
  endtask

  task automatic drive_beat(input int k, input int n, input logic [2:0] cb);
    wb_adr_i = ba[k]; wb_dat_i = bw[k]; wb_sel_i = bs[k];
    wb_cyc_i = 1'b1;  wb_stb_i = 1'b1;
    wb_cti_i = (cb == 3'b000) ? 3'b000 : ((k == n - 1) ? 3'b111 : cb);
  endtask

  // mode 0: full burst, 1: drop cyc after stop_n acks, 2: assert reset after stop_n acks
  task automatic burst(input logic we, input logic [2:0] cb, input logic [1:0] bte,
                       input logic [31:0] start, input int n, input int mode, input int stop_n,
                       output int nack, output int nerr);
    int beat;
    int unsigned t0;
    logic [31:0] a;
    bit active;
    nack = 0; nerr = 0; beat = 0; a = start;
    for (int k = 0; k < n; k++) begin ba[k] = a; a = m_next(a, cb, bte); end
    @(posedge wb_clk_i); #1;
    t0 = cycles;
    wb_we_i = we; wb_bte_i = bte;
    drive_beat(0, n, cb);
    active = 1'b1;
    for (int t = 0; t < n + 40 && active; t++) begin
      @(negedge wb_clk_i);
      if (wb_err_o) begin
        nerr++;
        bt[beat] = int'(cycles - t0);
        @(posedge wb_clk_i); #1;
        idle_bus();
        active = 1'b0;
      end else if (wb_ack_o) begin
        br[beat] = wb_dat_o;
        bt[beat] = int'(cycles - t0);
        if (!we && kn[ba[beat][7:2]] == 4'hF)
          check($sformatf("rd@%h", ba[beat]), wb_dat_o, mdl[ba[beat][7:2]]);
        if (we) model_write(ba[beat], bw[beat], bs[beat]);
        nack++; beat++;
        @(posedge wb_clk_i); #1;
        if (mode == 1 && beat == stop_n) begin
          idle_bus(); active = 1'b0;
        end else if (mode == 2 && beat == stop_n) begin
          wb_rst_i = 1'b0;
          #1;
          check("rst_drop", {30'b0, wb_ack_o, wb_err_o}, 32'd0);
          idle_bus();
          @(negedge wb_clk_i);
          wb_rst_i = 1'b1;
          active = 1'b0;
        end else if (beat < n) begin
          drive_beat(beat, n, cb);
        end else begin
          idle_bus(); active = 1'b0;
        end
      end
    end
    if (active) idle_bus();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, ne, n, g;
    logic [2:0]  cb;
    logic [1:0]  bte;
    logic        we;
    logic [31:0] st;

    idle_bus();
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_bte_i = '0;
    for (int i = 0; i < MW; i++) kn[i] = 4'h0;

    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_err", {31'b0, wb_err_o}, 32'd0);
    check("rst_rty", {31'b0, wb_rty_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    wb_rst_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);

    for (int k = 0; k < 64; k++) begin bw[k] = $urandom; bs[k] = 4'hF; end
    burst(1'b1, 3'b010, 2'b00, 32'h0, 64, 0, 0, na, ne);
    check("fill_ack", na, 64);
    check("fill_err", ne, 0);
    check("fill_lat", bt[0], WS + 1);
    check("fill_stream", bt[63] - bt[0], 63);

    bw[0] = 32'hDEADBEEF; bs[0] = 4'hF;
    burst(1'b1, 3'b000, 2'b00, 32'h10, 1, 0, 0, na, ne);
    check("cl_wr_lat", bt[0], WS + 1);
    burst(1'b0, 3'b000, 2'b00, 32'h10, 1, 0, 0, na, ne);
    check("cl_rd_lat", bt[0], WS + 1);
    check("cl_rd_dat", br[0], 32'hDEADBEEF);
    @(negedge wb_clk_i);
    check("cl_ack_1cyc", {31'b0, wb_ack_o}, 32'd0);

    for (int k = 0; k < 8; k++) begin bw[k] = 32'(k); bs[k] = 4'hF; end
    burst(1'b1, 3'b010, 2'b00, 32'h40, 8, 0, 0, na, ne);
    check("incw_ack", na, 8);
    check("incw_stream", bt[7] - bt[0], 7);
    burst(1'b0, 3'b010, 2'b00, 32'h40, 8, 0, 0, na, ne);
    check("incr_ack", na, 8);
    check("incr_stream", bt[7] - bt[0], 7);
    for (int k = 0; k < 8; k++) check($sformatf("incr_dat%0d", k), br[k], 32'(k));
    @(negedge wb_clk_i);
    check("incr_ack_drop", {31'b0, wb_ack_o}, 32'd0);

    bw[0] = 32'hAAAA0000; bw[1] = 32'hBBBB1111; bw[2] = 32'hCCCC2222; bw[3] = 32'hDDDD3333;
    for (int k = 0; k < 4; k++) bs[k] = 4'hF;
    burst(1'b1, 3'b010, 2'b00, 32'h0, 4, 0, 0, na, ne);
    burst(1'b0, 3'b010, 2'b01, 32'h08, 4, 0, 0, na, ne);
    check("wrap4_ack", na, 4);
    check("wrap4_b0", br[0], 32'hCCCC2222);
    check("wrap4_b1", br[1], 32'hDDDD3333);
    check("wrap4_b2", br[2], 32'hAAAA0000);
    check("wrap4_b3", br[3], 32'hBBBB1111);

    bw[0] = 32'h11223344; bs[0] = 4'hF;
    burst(1'b1, 3'b000, 2'b00, 32'h20, 1, 0, 0, na, ne);
    bw[0] = 32'hAABBCCDD; bs[0] = 4'b0101;
    burst(1'b1, 3'b000, 2'b00, 32'h20, 1, 0, 0, na, ne);
    bs[0] = 4'h0;
    burst(1'b0, 3'b000, 2'b00, 32'h20, 1, 0, 0, na, ne);
    check("bytemask", br[0], 32'h11BB33DD);

    burst(1'b0, 3'b000, 2'b00, 32'(4 * MW), 1, 0, 0, na, ne);
    check("oor_err", ne, 1);
    check("oor_ack", na, 0);
    @(negedge wb_clk_i);
    check("oor_err_pulse", {31'b0, wb_err_o}, 32'd0);
    burst(1'b0, 3'b010, 2'b00, 32'(4 * MW - 4), 2, 0, 0, na, ne);
    check("oor_rd_ack", na, 1);
    check("oor_rd_err", ne, 1);
    bw[0] = 32'h600DF00D; bw[1] = 32'hBAD0BAD0; bs[0] = 4'hF; bs[1] = 4'hF;
    burst(1'b1, 3'b010, 2'b00, 32'(4 * MW - 4), 2, 0, 0, na, ne);
    check("oor_wr_ack", na, 1);
    check("oor_wr_err", ne, 1);
    burst(1'b0, 3'b000, 2'b00, 32'(4 * MW - 4), 1, 0, 0, na, ne);
    burst(1'b0, 3'b000, 2'b00, 32'h0, 1, 0, 0, na, ne);

    for (int k = 0; k < 8; k++) begin bw[k] = $urandom; bs[k] = 4'hF; end
    burst(1'b1, 3'b010, 2'b00, 32'h80, 8, 1, 3, na, ne);
    check("abort_ack", na, 3);
    burst(1'b0, 3'b010, 2'b00, 32'h80, 8, 0, 0, na, ne);
    check("abort_rd_ack", na, 8);
    for (int k = 0; k < 8; k++) begin bw[k] = $urandom; bs[k] = 4'hF; end
    burst(1'b1, 3'b010, 2'b00, 32'hA0, 8, 2, 2, na, ne);
    check("rstmid_ack", na, 2);
    burst(1'b0, 3'b010, 2'b00, 32'hA0, 8, 0, 0, na, ne);
    check("rstmid_idle_lat", bt[0], WS + 1);
    check("rstmid_rd_ack", na, 8);

    for (int it = 0; it < 40; it++) begin
      we  = 1'($urandom_range(0, 1));
      st  = 32'($urandom_range(0, MW - 1)) * 4;
      bte = 2'b00;
      case ($urandom_range(0, 3))
        0:       begin cb = 3'b000; n = 1; end
        1:       begin cb = 3'b001; n = $urandom_range(1, 6); end
        2:       begin cb = 3'b010; n = $urandom_range(1, 8); end
        default: begin cb = 3'b010; n = $urandom_range(1, 8); bte = 2'($urandom_range(1, 3)); end
      endcase
      for (int k = 0; k < n; k++) begin bw[k] = $urandom; bs[k] = 4'($urandom_range(0, 15)); end
      burst(we, cb, bte, st, n, 0, 0, na, ne);
      g = exp_good(n);
      check($sformatf("rnd%0d_ack", it), na, g);
      check($sformatf("rnd%0d_err", it), ne, (g < n) ? 1 : 0);
      if (g > 0) check($sformatf("rnd%0d_lat", it), bt[0], WS + 1);
      if (g > 1) check($sformatf("rnd%0d_stream", it), bt[g-1] - bt[0], g - 1);
      @(negedge wb_clk_i);
      check($sformatf("rnd%0d_idle", it), {30'b0, wb_ack_o, wb_err_o}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
